// File: rtl/base_acombine_buf_pkg.sv
// Shared constants and helpers for the buffered valid/ready combiner.
// Holds default payload/counter widths and the payload slice offset.
package base_acombine_pkg;

    localparam int unsigned DW_DEF = 8;
    localparam int unsigned CW_DEF = 32;

    // Offset of stream j inside an ascending-range packed payload bus.
    function automatic int slice_off(input int j, input int w);
        return j * w;
    endfunction

endpackage

// File: rtl/base_acombine_buf_ahold.sv
// One-entry valid/data holding register for a single input stream.
// Ports: clk, reset_n (sync, active-low), accept, fire, d -> q_v, q_d.
module base_ahold
    import base_acombine_pkg::*;
#(
    parameter int unsigned dw = DW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          accept,
    input  logic          fire,
    input  logic [dw-1:0] d,
    output logic          q_v,
    output logic [dw-1:0] q_d
);

    logic          v_q;
    logic          v_d;
    logic [dw-1:0] data_q;
    logic [dw-1:0] data_d;

    // A same-cycle accept keeps the entry full even when it fires,
    // which is what sustains one transaction per cycle.
    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (accept) begin
            v_d    = 1'b1;
            data_d = d;
        end else if (fire) begin
            v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v_q    <= 1'b0;
            data_q <= '0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

    assign q_v = v_q;
    assign q_d = data_q;

endmodule

// File: rtl/base_acombine_buf.sv
// Buffered join of ni payload streams forked to no independently drained outputs.
// Ports: clk, reset_n, i_v/i_r/i_d (inputs), o_v/o_r/o_d (outputs), o_cnt.
// o_cnt counts fires only when BASE_ACOMBINE_BUF_CNT_EN is defined, else 0.
// i_r depends combinationally on o_r; instantiating logic must not close a
// loop from i_r back to o_r.
module base_acombine_buf
    import base_acombine_pkg::*;
#(
    parameter int unsigned ni = 2,
    parameter int unsigned no = 2,
    parameter int unsigned dw = DW_DEF,
    parameter int unsigned cw = CW_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [0:ni-1]    i_v,
    output logic [0:ni-1]    i_r,
    input  logic [0:ni*dw-1] i_d,
    output logic [0:no-1]    o_v,
    input  logic [0:no-1]    o_r,
    output logic [0:ni*dw-1] o_d,
    output logic [0:cw-1]    o_cnt
);

    logic [0:ni-1]    hold_v;
    logic [0:ni*dw-1] hold_cat;
    logic             ofree;
    logic             fire;
    logic [0:no-1]    ov_q;
    logic [0:no-1]    ov_d;
    logic [0:ni*dw-1] od_q;
    logic [0:ni*dw-1] od_d;

    // Output stage is free when every output is either empty or draining now.
    assign ofree = &(~ov_q | o_r);
    assign fire  = (&hold_v) & ofree;
    assign i_r   = ~hold_v | {ni{fire}};

    for (genvar j = 0; j < ni; j++) begin : g_hold
        logic [dw-1:0] q_d;

        base_ahold #(
            .dw(dw)
        ) u_hold (
            .clk    (clk),
            .reset_n(reset_n),
            .accept (i_v[j] & i_r[j]),
            .fire   (fire),
            .d      (i_d[slice_off(j, dw) +: dw]),
            .q_v    (hold_v[j]),
            .q_d    (q_d)
        );

        assign hold_cat[slice_off(j, dw) +: dw] = q_d;
    end

    // Fire reloads every output, overriding any same-cycle drain.
    always_comb begin
        ov_d = ov_q & ~o_r;
        od_d = od_q;
        if (fire) begin
            ov_d = '1;
            od_d = hold_cat;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ov_q <= '0;
            od_q <= '0;
        end else begin
            ov_q <= ov_d;
            od_q <= od_d;
        end
    end

    assign o_v = ov_q;
    assign o_d = od_q;

`ifdef BASE_ACOMBINE_BUF_CNT_EN
    logic [cw-1:0] cnt_q;
    logic [cw-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (fire) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;
`else
    assign o_cnt = '0;
`endif

endmodule

// File: tb/tb_base_acombine_buf.sv
// Self-checking bench for base_acombine_buf (ni=2, no=2, dw=8).
// Directed timing scenarios plus a queue-based transaction scoreboard.
module tb_base_acombine_buf;

`ifdef BASE_ACOMBINE_BUF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [0:1]  i_v = '0;
    logic [0:1]  i_r;
    logic [0:15] i_d = '0;
    logic [0:1]  o_v;
    logic [0:1]  o_r = '0;
    logic [0:15] o_d;
    logic [0:31] o_cnt;

    logic [0:1]  i_r4;
    logic [0:1]  o_v4;
    logic [0:15] o_d4;
    logic [0:3]  o_cnt4;

    int nrun = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    base_acombine_buf #(.ni(2), .no(2), .dw(8), .cw(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_v(i_v), .i_r(i_r), .i_d(i_d),
        .o_v(o_v), .o_r(o_r), .o_d(o_d),
        .o_cnt(o_cnt)
    );

    base_acombine_buf #(.ni(2), .no(2), .dw(8), .cw(4)) dut4 (
        .clk(clk), .reset_n(reset_n),
        .i_v(i_v), .i_r(i_r4), .i_d(i_d),
        .o_v(o_v4), .o_r(o_r), .o_d(o_d4),
        .o_cnt(o_cnt4)
    );

    // Reference model: the n-th payload accepted on every input forms
    // transaction n; each output must deliver all transactions in order.
    logic [7:0]  inq  [2][$];
    logic [15:0] expq [2][$];
    int          formed = 0;
    int          deliv [2] = '{0, 0};
    logic [15:0] mon_e;
    logic [15:0] mon_t;

    always @(negedge clk) begin
        if (!reset_n) begin
            for (int j = 0; j < 2; j++) inq[j].delete();
            for (int k = 0; k < 2; k++) expq[k].delete();
            formed = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (o_v[k] && o_r[k]) begin
                    nrun++;
                    if (expq[k].size() == 0) begin
                        nfail++;
                        $display("FAIL sb_out%0d_extra got %h required none", k, o_d);
                    end else begin
                        mon_e = expq[k].pop_front();
                        deliv[k]++;
                        if (o_d !== mon_e) begin
                            nfail++;
                            $display("FAIL sb_out%0d_data got %h required %h", k, o_d, mon_e);
                        end
                    end
                end
            end
            for (int j = 0; j < 2; j++)
                if (i_v[j] && i_r[j]) inq[j].push_back(i_d[j*8 +: 8]);
            while (inq[0].size() > 0 && inq[1].size() > 0) begin
                mon_t = {inq[0].pop_front(), inq[1].pop_front()};
                expq[0].push_back(mon_t);
                expq[1].push_back(mon_t);
                formed++;
            end
        end
    end

    function automatic logic [31:0] exp_cnt();
        return CNT_EN ? 32'(formed) : 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        i_v = '0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic drain();
        i_v = '0;
        o_r = 2'b11;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        i_v = 2'b11;
        i_d = 16'(($urandom));
        o_r = 2'b11;
        repeat (2) tick();
        reset_n = 1'b1;
        i_v = '0;
        @(negedge clk);
        nrun++;
        if ({o_v, i_r, o_d, o_cnt, o_cnt4} !== {2'b00, 2'b11, 16'h0, 32'h0, 4'h0}) begin
            nfail++;
            $display("FAIL reset_state got o_v=%b i_r=%b o_d=%h cnt=%h cnt4=%h required 00 11 0000 0 0",
                     o_v, i_r, o_d, o_cnt, o_cnt4);
        end
        tick();
    endtask

    task automatic test_basic();
        o_r = 2'b11;
        i_v = 2'b11;
        i_d = {8'hA5, 8'h3C};
        @(negedge clk);
        nrun++;
        if ({i_r, o_v} !== 4'b1100) begin
            nfail++;
            $display("FAIL basic_c0 got i_r/o_v=%b required 1100", {i_r, o_v});
        end
        tick();
        i_v = '0;
        @(negedge clk);
        nrun++;
        if ({i_r, o_v} !== 4'b1100) begin
            nfail++;
            $display("FAIL basic_c1 got i_r/o_v=%b required 1100", {i_r, o_v});
        end
        tick();
        @(negedge clk);
        nrun++;
        if ({o_v, o_d} !== {2'b11, 16'hA53C}) begin
            nfail++;
            $display("FAIL basic_c2 got o_v=%b o_d=%h required 11 a53c", o_v, o_d);
        end
        tick();
        @(negedge clk);
        nrun++;
        if (o_v !== 2'b00) begin
            nfail++;
            $display("FAIL basic_c3 got o_v=%b required 00", o_v);
        end
        tick();
    endtask

    task automatic test_skew();
        o_r = 2'b11;
        i_v = 2'b10;
        i_d = {8'h11, 8'hEE};
        @(negedge clk);
        tick();
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) begin
                i_v = 2'b01;
                i_d = {8'hDD, 8'h22};
            end else begin
                i_v = 2'b00;
                i_d = 16'(($urandom));
            end
            @(negedge clk);
            nrun++;
            if ({i_r[0], o_v} !== 3'b000) begin
                nfail++;
                $display("FAIL skew_c%0d got i_r0=%b o_v=%b required 0 00", c, i_r[0], o_v);
            end
            tick();
        end
        i_v = '0;
        @(negedge clk);
        nrun++;
        if ({i_r, o_v} !== 4'b1100) begin
            nfail++;
            $display("FAIL skew_c6 got i_r/o_v=%b required 1100", {i_r, o_v});
        end
        tick();
        @(negedge clk);
        nrun++;
        if ({o_v, o_d} !== {2'b11, 16'h1122}) begin
            nfail++;
            $display("FAIL skew_c7 got o_v=%b o_d=%h required 11 1122", o_v, o_d);
        end
        tick();
    endtask

    task automatic test_partial_drain();
        logic [15:0] a;
        logic [15:0] b;
        a = 16'($urandom);
        b = 16'($urandom);
        o_r = 2'b11;
        i_v = 2'b11;
        i_d = a;
        tick();
        i_d = b;
        tick();
        i_v = '0;
        o_r = 2'b10;
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            nrun++;
            if ({o_v, o_d, i_r} !== {(c == 2) ? 2'b11 : 2'b01, a, 2'b00}) begin
                nfail++;
                $display("FAIL pdrain_c%0d got o_v=%b o_d=%h i_r=%b required %b %h 00",
                         c, o_v, o_d, i_r, (c == 2) ? 2'b11 : 2'b01, a);
            end
            tick();
        end
        o_r = 2'b01;
        @(negedge clk);
        nrun++;
        if ({o_v, i_r} !== 4'b0111) begin
            nfail++;
            $display("FAIL pdrain_c5 got o_v=%b i_r=%b required 01 11", o_v, i_r);
        end
        tick();
        o_r = 2'b11;
        @(negedge clk);
        nrun++;
        if ({o_v, o_d} !== {2'b11, b}) begin
            nfail++;
            $display("FAIL pdrain_c6 got o_v=%b o_d=%h required 11 %h", o_v, o_d, b);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int d0;
        int d1;
        logic [7:0] x;
        pulse_reset();
        d0 = deliv[0];
        d1 = deliv[1];
        o_r = 2'b11;
        for (int i = 0; i < 102; i++) begin
            i_v = (i < 100) ? 2'b11 : 2'b00;
            x = 8'(i);
            i_d = {x, x ^ 8'h5A};
            @(negedge clk);
            if (i < 100) begin
                nrun++;
                if (i_r !== 2'b11) begin
                    nfail++;
                    $display("FAIL b2b_ready_%0d got %b required 11", i, i_r);
                end
            end
            if (i >= 2) begin
                x = 8'(i - 2);
                nrun++;
                if ({o_v, o_d} !== {2'b11, x, x ^ 8'h5A}) begin
                    nfail++;
                    $display("FAIL b2b_out_%0d got o_v=%b o_d=%h required 11 %h",
                             i - 2, o_v, o_d, {x, x ^ 8'h5A});
                end
            end
            tick();
        end
        drain();
        @(negedge clk);
        nrun++;
        if ((deliv[0] - d0) != 100 || (deliv[1] - d1) != 100 || o_cnt !== exp_cnt()) begin
            nfail++;
            $display("FAIL b2b_count got %0d/%0d cnt=%0d required 100/100 cnt=%0d",
                     deliv[0] - d0, deliv[1] - d1, o_cnt, exp_cnt());
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            i_v = 2'($urandom);
            o_r = 2'($urandom);
            i_d = 16'($urandom);
            tick();
        end
        drain();
        @(negedge clk);
        nrun++;
        if (expq[0].size() != 0 || expq[1].size() != 0 || deliv[0] != deliv[1]
            || o_cnt !== exp_cnt()) begin
            nfail++;
            $display("FAIL random_end got pend=%0d/%0d deliv=%0d/%0d cnt=%0d required 0/0 equal cnt=%0d",
                     expq[0].size(), expq[1].size(), deliv[0], deliv[1], o_cnt, exp_cnt());
        end
        tick();
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        o_r = 2'b00;
        i_v = 2'b11;
        i_d = 16'hBEEF;
        tick();
        i_d = 16'hCAFE;
        tick();
        i_v = '0;
        @(negedge clk);
        nrun++;
        if ({o_v, i_r} !== 4'b1100) begin
            nfail++;
            $display("FAIL rmid_full got o_v=%b i_r=%b required 11 00", o_v, i_r);
        end
        tick();
        reset_n = 1'b0;
        i_v = 2'b11;
        i_d = 16'h5555;
        tick();
        reset_n = 1'b1;
        i_v = '0;
        o_r = 2'b11;
        @(negedge clk);
        nrun++;
        if ({o_v, i_r, o_d, o_cnt, o_cnt4} !== {2'b00, 2'b11, 16'h0, 32'h0, 4'h0}) begin
            nfail++;
            $display("FAIL rmid_after got o_v=%b i_r=%b o_d=%h cnt=%h cnt4=%h required 00 11 0000 0 0",
                     o_v, i_r, o_d, o_cnt, o_cnt4);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            @(negedge clk);
            nrun++;
            if (o_v !== 2'b00) begin
                nfail++;
                $display("FAIL rmid_quiet_%0d got o_v=%b required 00", c, o_v);
            end
        end
        tick();
    endtask

    task automatic test_cnt_wrap();
        logic [3:0] e4;
        pulse_reset();
        o_r = 2'b11;
        for (int i = 0; i < 17; i++) begin
            i_v = 2'b11;
            i_d = 16'($urandom);
            tick();
        end
        drain();
        e4 = CNT_EN ? 4'd1 : 4'd0;
        @(negedge clk);
        nrun++;
        if (o_cnt4 !== e4 || o_cnt !== exp_cnt() || formed != 17) begin
            nfail++;
            $display("FAIL cnt_wrap got cnt4=%0d cnt=%0d txns=%0d required %0d %0d 17",
                     o_cnt4, o_cnt, formed, e4, exp_cnt());
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skew();
        test_partial_drain();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_cnt_wrap();
        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end

endmodule
